// File: rtl/data_slicer_ctrl.sv
// data_slicer_ctrl: job sequencer for the data slicer.
//
// Captures a job (mode, element size, word count) from CSRs and clears the slicer.
// It then passes exactly num_words low-dim words from the streamer into the slicer.
// After the last word it waits for the slicer address FIFO to drain, then reports done.
// An abort flushes the slicer and returns to idle without a done pulse.
//
// Optional feature: define DATA_SLICER_CTRL_PERF_EN to build the stall counter.
// When it is not defined, perf_stall_cnt_o is tied to 0.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   csr_start_i/abort_i      single-cycle job start / abort pulses
//   csr_mode_i, csr_elem_size_i, csr_num_words_i   job configuration
//   busy_o, done_o           status (busy in any non-idle state, done is a 1-cycle pulse)
//   addr_count_o             address handshakes seen in the current/last job
//   perf_stall_cnt_o         RUN cycles where a word was offered but the slicer was not ready
//   src_valid_i/src_ready_o  streamer low-dim handshake (gated)
//   slicer_*                 slicer control: enable, clear, latched config, gated valid, ready
//   addr_valid_i/ready_i     slicer address output handshake (monitored only)
`timescale 1ns/1ps

module data_slicer_ctrl #(
  parameter int unsigned CsrDataWidth = 32,
  parameter int unsigned ModeWidth    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    csr_start_i,
  input  logic                    csr_abort_i,
  input  logic [ModeWidth-1:0]    csr_mode_i,
  input  logic [CsrDataWidth-1:0] csr_elem_size_i,
  input  logic [CsrDataWidth-1:0] csr_num_words_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CsrDataWidth-1:0] addr_count_o,
  output logic [CsrDataWidth-1:0] perf_stall_cnt_o,
  input  logic                    src_valid_i,
  output logic                    src_ready_o,
  output logic                    slicer_enable_o,
  output logic                    slicer_clr_o,
  output logic [ModeWidth-1:0]    slicer_sel_mode_o,
  output logic [CsrDataWidth-1:0] slicer_elem_size_o,
  output logic                    slicer_valid_o,
  input  logic                    slicer_ready_i,
  input  logic                    addr_valid_i,
  input  logic                    addr_ready_i
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StDrain,
    StDone,
    StFlush
  } state_e;

  state_e                  state_q, state_d;
  logic [ModeWidth-1:0]    mode_q, mode_d;
  logic [CsrDataWidth-1:0] elem_size_q, elem_size_d;
  logic [CsrDataWidth-1:0] num_words_q, num_words_d;
  logic [CsrDataWidth-1:0] word_cnt_q, word_cnt_d;
  logic [CsrDataWidth-1:0] addr_cnt_q, addr_cnt_d;
  logic [CsrDataWidth-1:0] word_inc;
  logic                    active;
  logic                    addr_hs;

  assign active   = (word_cnt_q < num_words_q);
  assign word_inc = word_cnt_q + CsrDataWidth'(1);
  assign addr_hs  = addr_valid_i & addr_ready_i;

  assign slicer_sel_mode_o  = mode_q;
  assign slicer_elem_size_o = elem_size_q;
  assign addr_count_o       = addr_cnt_q;

  always_comb begin
    state_d         = state_q;
    mode_d          = mode_q;
    elem_size_d     = elem_size_q;
    num_words_d     = num_words_q;
    word_cnt_d      = word_cnt_q;
    addr_cnt_d      = addr_cnt_q;
    busy_o          = 1'b1;
    done_o          = 1'b0;
    src_ready_o     = 1'b0;
    slicer_enable_o = 1'b0;
    slicer_clr_o    = 1'b0;
    slicer_valid_o  = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy_o = 1'b0;
        // Start beats a simultaneous abort here: abort is a no-op while idle.
        if (csr_start_i) begin
          mode_d      = csr_mode_i;
          elem_size_d = csr_elem_size_i;
          num_words_d = csr_num_words_i;
          word_cnt_d  = '0;
          addr_cnt_d  = '0;
          state_d     = StClear;
        end
      end
      StClear: begin
        slicer_clr_o = 1'b1;
        state_d      = (num_words_q == '0) ? StDone : StRun;
        if (csr_abort_i) state_d = StFlush;
      end
      StRun: begin
        slicer_enable_o = 1'b1;
        slicer_valid_o  = src_valid_i & active;
        src_ready_o     = slicer_ready_i & active;
        if (addr_hs) addr_cnt_d = addr_cnt_q + CsrDataWidth'(1);
        if (src_valid_i && src_ready_o) begin
          word_cnt_d = word_inc;
          if (word_inc == num_words_q) state_d = StDrain;
        end
        if (csr_abort_i) state_d = StFlush;
      end
      StDrain: begin
        slicer_enable_o = 1'b1;
        if (addr_hs) addr_cnt_d = addr_cnt_q + CsrDataWidth'(1);
        if (!addr_valid_i) state_d = StDone;
        if (csr_abort_i) state_d = StFlush;
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      StFlush: begin
        slicer_clr_o = 1'b1;
        state_d      = StIdle;
      end
      default: begin
        busy_o  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      mode_q      <= '0;
      elem_size_q <= '0;
      num_words_q <= '0;
      word_cnt_q  <= '0;
      addr_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      elem_size_q <= elem_size_d;
      num_words_q <= num_words_d;
      word_cnt_q  <= word_cnt_d;
      addr_cnt_q  <= addr_cnt_d;
    end
  end

`ifdef DATA_SLICER_CTRL_PERF_EN
  logic [CsrDataWidth-1:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == StIdle && csr_start_i) begin
      perf_d = '0;
    end else if (state_q == StRun && src_valid_i && active && !slicer_ready_i) begin
      perf_d = perf_q + CsrDataWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_stall_cnt_o = perf_q;
`else
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_data_slicer_ctrl.sv
// Self-checking bench for data_slicer_ctrl.
// A small slicer stub turns each accepted word into a fixed number of addresses.
// A high-level job model predicts handshakes, address totals and stall counts.
`timescale 1ns/1ps

module tb_data_slicer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_start, csr_abort;
  logic [1:0]  csr_mode;
  logic [31:0] csr_elem, csr_nw;
  logic        busy, done;
  logic [31:0] addr_count, perf_cnt;
  logic        src_valid, src_ready;
  logic        sl_enable, sl_clr, sl_valid, sl_ready;
  logic [1:0]  sl_mode;
  logic [31:0] sl_elem;
  logic        addr_valid, addr_ready;

  int checks = 0;
  int errors = 0;

  // Slicer stub: queue depth of pending addresses.
  int unsigned stub_cnt = 0;
  int unsigned apw = 1;

  always #5 clk = ~clk;

  data_slicer_ctrl #(
    .CsrDataWidth(32),
    .ModeWidth   (2)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .csr_start_i       (csr_start),
    .csr_abort_i       (csr_abort),
    .csr_mode_i        (csr_mode),
    .csr_elem_size_i   (csr_elem),
    .csr_num_words_i   (csr_nw),
    .busy_o            (busy),
    .done_o            (done),
    .addr_count_o      (addr_count),
    .perf_stall_cnt_o  (perf_cnt),
    .src_valid_i       (src_valid),
    .src_ready_o       (src_ready),
    .slicer_enable_o   (sl_enable),
    .slicer_clr_o      (sl_clr),
    .slicer_sel_mode_o (sl_mode),
    .slicer_elem_size_o(sl_elem),
    .slicer_valid_o    (sl_valid),
    .slicer_ready_i    (sl_ready),
    .addr_valid_i      (addr_valid),
    .addr_ready_i      (addr_ready)
  );

  assign addr_valid = (stub_cnt != 0);

  always @(posedge clk) begin
    if (rst || sl_clr) begin
      stub_cnt <= 0;
    end else begin
      stub_cnt <= stub_cnt + ((sl_valid && sl_ready) ? apw : 0)
                           - ((addr_valid && addr_ready) ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    csr_start  = 1'b0;
    csr_abort  = 1'b0;
    src_valid  = 1'b0;
    sl_ready   = 1'b0;
    addr_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    src_valid = 1'b1;
    sl_ready  = 1'b1;
    csr_mode  = 2'd0;
    csr_elem  = 32'd0;
    csr_nw    = 32'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("reset_outputs",
          {busy, done, addr_count, perf_cnt, src_ready, sl_enable, sl_clr, sl_mode, sl_elem,
           sl_valid}, '0);
    end
    step();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
  endtask

  // Runs one job through to done, checking gating and completion against the model.
  task automatic do_job(input logic [1:0] mode, input logic [31:0] elem, input int unsigned nw,
                        input int unsigned apw_i, input int unsigned hold, input string name);
    int unsigned acc = 0;
    int unsigned stalls = 0;
    int unsigned dones = 0;
    bit          exp_act;
    logic        exp_sr, exp_sv;
    apw = apw_i;
    step();
    idle_inputs();
    csr_start = 1'b1;
    csr_mode  = mode;
    csr_elem  = elem;
    csr_nw    = nw;
    @(negedge clk);
    step();
    csr_start = 1'b0;
    csr_mode  = ~mode;
    csr_elem  = $urandom;
    csr_nw    = $urandom_range(0, 9);
    @(negedge clk);
    chk({name, "_clear"}, {sl_clr, sl_enable, busy, done}, 4'b1010);
    if (nw == 0) begin
      step();
      @(negedge clk);
      chk({name, "_zero_done"}, {done, sl_enable, busy}, 3'b101);
      dones = 1;
    end else begin
      for (int cyc = 0; cyc < 3000 && dones == 0; cyc++) begin
        step();
        src_valid  = ($urandom_range(0, 3) != 0);
        sl_ready   = $urandom_range(0, 1);
        addr_ready = (cyc < hold) ? 1'b0 : ($urandom_range(0, 3) != 0);
        csr_start  = ($urandom_range(0, 3) == 0);
        csr_mode   = $urandom;
        csr_elem   = $urandom;
        csr_nw     = $urandom_range(0, 9);
        @(negedge clk);
        exp_act = (acc < nw);
        exp_sr  = sl_ready & exp_act;
        exp_sv  = src_valid & exp_act;
        chk({name, "_gating"}, {src_ready, sl_valid}, {exp_sr, exp_sv});
        chk({name, "_latched_cfg"}, {sl_mode, sl_elem}, {mode, elem});
        if (cyc < hold) chk({name, "_no_done_in_hold"}, done, 1'b0);
        if (done) begin
          dones++;
          chk({name, "_done_state"}, {acc == nw, stub_cnt == 0, sl_enable, busy}, 4'b1101);
        end else begin
          chk({name, "_active"}, {sl_enable, busy}, 2'b11);
        end
        if (exp_act && src_valid && !sl_ready) stalls++;
        if (src_valid && exp_sr) acc++;
      end
      chk({name, "_done_seen"}, dones, 1);
    end
    chk({name, "_addr_count"}, addr_count, 32'(nw * apw_i));
`ifdef DATA_SLICER_CTRL_PERF_EN
    chk({name, "_perf"}, perf_cnt, 32'(stalls));
`else
    chk({name, "_perf_off"}, perf_cnt, 32'd0);
`endif
    step();
    idle_inputs();
    src_valid = 1'b1;
    sl_ready  = 1'b1;
    @(negedge clk);
    chk({name, "_idle_after"}, {busy, done, src_ready, sl_valid, sl_enable}, 5'b0);
    step();
    @(negedge clk);
    chk({name, "_addr_hold"}, addr_count, 32'(nw * apw_i));
  endtask

  task automatic test_directed();
    do_job(2'd0, 32'd0, 3, 1, 0, "mode0");
    do_job(2'd3, 32'd8, 2, 8, 0, "mode3");
    do_job(2'd1, 32'd100, 2, 50, 0, "mode1");
    do_job(2'd2, 32'd5, 2, 5, 0, "mode2");
    do_job(2'd3, 32'd8, 3, 8, 20, "hold");
  endtask

  task automatic test_random();
    for (int j = 0; j < 6; j++) begin
      logic [1:0] m;
      m = $urandom;
      do_job(m, $urandom, $urandom_range(1, 6), (m == 0) ? 1 : $urandom_range(1, 4),
             $urandom_range(0, 1) * $urandom_range(1, 15), "rand");
    end
  endtask

  task automatic test_abort();
    apw = 2;
    step();
    idle_inputs();
    csr_start = 1'b1;
    csr_mode  = 2'd2;
    csr_elem  = 32'd5;
    csr_nw    = 32'd4;
    @(negedge clk);
    step();
    csr_start = 1'b0;
    @(negedge clk);
    step();
    src_valid  = 1'b1;
    sl_ready   = 1'b1;
    addr_ready = 1'b1;
    @(negedge clk);
    chk("abort_first_word_ready", {src_ready, sl_valid}, 2'b11);
    step();
    src_valid = 1'b0;
    csr_abort = 1'b1;
    @(negedge clk);
    chk("abort_busy_in_run", busy, 1'b1);
    step();
    csr_abort = 1'b0;
    @(negedge clk);
    chk("abort_flush", {sl_clr, sl_enable, src_ready, sl_valid, busy, done}, 6'b100010);
    step();
    @(negedge clk);
    chk("abort_idle", {busy, done, sl_clr}, 3'b000);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("abort_no_done", done, 1'b0);
    end
    // Zero-word job: CLEAR then DONE.
    step();
    csr_start = 1'b1;
    csr_nw    = 32'd0;
    @(negedge clk);
    step();
    csr_start = 1'b0;
    @(negedge clk);
    chk("zero_clear", {sl_clr, busy, done}, 3'b110);
    step();
    @(negedge clk);
    chk("zero_done", {done, busy, addr_count}, {2'b11, 32'd0});
    step();
    @(negedge clk);
    chk("zero_idle", {busy, done}, 2'b00);
    // Abort while idle does nothing.
    step();
    csr_abort = 1'b1;
    @(negedge clk);
    step();
    csr_abort = 1'b0;
    @(negedge clk);
    chk("abort_idle_noop", {busy, sl_clr}, 2'b00);
    // Start and abort together in idle: start wins, then abort in CLEAR flushes.
    step();
    csr_start = 1'b1;
    csr_abort = 1'b1;
    csr_mode  = 2'd1;
    csr_nw    = 32'd2;
    @(negedge clk);
    step();
    csr_start = 1'b0;
    csr_abort = 1'b1;
    @(negedge clk);
    chk("start_wins", {sl_clr, busy, sl_mode}, {2'b11, 2'd1});
    step();
    csr_abort = 1'b0;
    @(negedge clk);
    chk("abort_in_clear", {sl_clr, busy, done, sl_enable}, 4'b1100);
    step();
    @(negedge clk);
    chk("abort_clear_idle", busy, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    apw = 3;
    step();
    idle_inputs();
    csr_start = 1'b1;
    csr_mode  = 2'd3;
    csr_elem  = 32'd8;
    csr_nw    = 32'd4;
    @(negedge clk);
    step();
    csr_start = 1'b0;
    @(negedge clk);
    step();
    src_valid  = 1'b1;
    sl_ready   = 1'b1;
    addr_ready = 1'b1;
    @(negedge clk);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("pre_reset_busy", {busy, sl_enable}, 2'b11);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_reset_outputs",
        {busy, done, addr_count, perf_cnt, src_ready, sl_enable, sl_clr, sl_mode, sl_elem,
         sl_valid}, '0);
    step();
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
